is_dual_issue_scheduler: RTL and testbench

//  Issue-stage scheduler between ID and EX. Latches one decoded pair per ID handshake and

---
 rtl/is_dual_issue_scheduler_if.sv | 50 +++++
 rtl/is_dual_issue_scheduler.sv | 173 +++++++++++++++++
 tb/tb_is_dual_issue_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/is_dual_issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// is_dual_issue_scheduler_if
//   Bundles the ID->issue pair handshake and the issue->EX lane bus.
//   master : ID/EX side (drives id_* and ex_allin, observes is_allin/iss_*)
//   slave  : the scheduler (consumes id_*/ex_allin, drives is_allin/iss_*)
// Signals
//   id_valid_ns / is_allin        : ID pair handshake
//   id_pc_*, id_info_*, id_vld_*  : per-slot PC, opaque payload, valid
//   id_dst_* [5]=we [4:0]=index   : destination register
//   id_src_* {en1,src1,en0,src0}  : source registers
//   id_cls_*, id_exc_*, id_delot  : class, exception, delay-slot flags
//   ex_allin                      : EX accepts presented lanes
//   iss_valid_*, iss_pc_*, iss_info_*, iss_delot_* : issue lanes
// ---------------------------------------------------------------------------
interface is_dual_issue_scheduler_if #(
  parameter int INFO_W = 55,
  parameter int CLS_W  = 3
);
  logic              id_valid_ns;
  logic              is_allin;
  logic [31:0]       id_pc_0, id_pc_1;
  logic [INFO_W-1:0] id_info_0, id_info_1;
  logic              id_vld_0, id_vld_1;
  logic [5:0]        id_dst_0, id_dst_1;
  logic [11:0]       id_src_0, id_src_1;
  logic [CLS_W-1:0]  id_cls_0, id_cls_1;
  logic              id_exc_0, id_exc_1;
  logic [1:0]        id_delot;
  logic              ex_allin;
  logic              iss_valid_0, iss_valid_1;
  logic [31:0]       iss_pc_0, iss_pc_1;
  logic [INFO_W-1:0] iss_info_0, iss_info_1;
  logic              iss_delot_0, iss_delot_1;

  modport master (
    output id_valid_ns, id_pc_0, id_pc_1, id_info_0, id_info_1, id_vld_0, id_vld_1,
           id_dst_0, id_dst_1, id_src_0, id_src_1, id_cls_0, id_cls_1,
           id_exc_0, id_exc_1, id_delot, ex_allin,
    input  is_allin, iss_valid_0, iss_valid_1, iss_pc_0, iss_pc_1,
           iss_info_0, iss_info_1, iss_delot_0, iss_delot_1
  );

  modport slave (
    input  id_valid_ns, id_pc_0, id_pc_1, id_info_0, id_info_1, id_vld_0, id_vld_1,
           id_dst_0, id_dst_1, id_src_0, id_src_1, id_cls_0, id_cls_1,
           id_exc_0, id_exc_1, id_delot, ex_allin,
    output is_allin, iss_valid_0, iss_valid_1, iss_pc_0, iss_pc_1,
           iss_info_0, iss_info_1, iss_delot_0, iss_delot_1
  );
endinterface

// File: rtl/is_dual_issue_scheduler.sv
// ---------------------------------------------------------------------------
// is_dual_issue_scheduler
//   Issue-stage scheduler between ID and EX. Holds one decoded pair and
//   issues it as a dual pair, or splits it (slot0 first, then slot1 on
//   lane0) when a register hazard, structural conflict, exception or SYS
//   instruction forbids pairing.
// Ports
//   clk    : clock
//   rst    : synchronous active-high reset
//   flush  : synchronous pipeline flush, discards held pair
//   bus    : is_dual_issue_scheduler_if.slave (ID handshake + issue lanes)
//   perf_dual_cnt / perf_single_cnt : transfer counters (IS_PERF_CNT_EN only)
// Configuration macro: IS_PERF_CNT_EN
//
// State table
//   state     | meaning
//   ST_EMPTY  | no pair held, ready for ID
//   ST_PAIR   | full pair held, slot0 (and slot1 if pairable) on lanes
//   ST_SECOND | slot0 already issued, slot1 pending on lane0
// ---------------------------------------------------------------------------
module is_dual_issue_scheduler #(
  parameter int INFO_W = 55,
  parameter int CLS_W  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  is_dual_issue_scheduler_if.slave bus
`ifdef IS_PERF_CNT_EN
  ,
  output logic [31:0] perf_dual_cnt,
  output logic [31:0] perf_single_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_PAIR   = 2'd1;
  localparam logic [1:0] ST_SECOND = 2'd2;

  localparam logic [CLS_W-1:0] CLS_MUL = CLS_W'(1);
  localparam logic [CLS_W-1:0] CLS_LSU = CLS_W'(2);
  localparam logic [CLS_W-1:0] CLS_BR  = CLS_W'(3);
  localparam logic [CLS_W-1:0] CLS_SYS = CLS_W'(4);

  logic [1:0]        r_state;
  logic [31:0]       r_pc_0, r_pc_1;
  logic [INFO_W-1:0] r_info_0, r_info_1;
  logic              r_vld_0, r_vld_1;
  logic [5:0]        r_dst_0, r_dst_1;
  logic [11:0]       r_src_0, r_src_1;
  logic [CLS_W-1:0]  r_cls_0, r_cls_1;
  logic              r_exc_0, r_exc_1;
  logic [1:0]        r_delot;

  logic w_raw, w_waw, w_struct, w_dual_ok, w_split, w_done, w_capture;

  // r_src_0 travels with the pair for completeness; only slot1's sources
  // can depend on slot0's result inside a pair.
  always_comb begin
    w_raw = r_dst_0[5] && (r_dst_0[4:0] != 5'd0) &&
            ((r_src_1[5]  && (r_src_1[4:0]  == r_dst_0[4:0])) ||
             (r_src_1[11] && (r_src_1[10:6] == r_dst_0[4:0])));
    w_waw = r_dst_0[5] && r_dst_1[5] && (r_dst_0[4:0] == r_dst_1[4:0]) &&
            (r_dst_0[4:0] != 5'd0);
    w_struct = (r_cls_0 == r_cls_1) &&
               ((r_cls_0 == CLS_MUL) || (r_cls_0 == CLS_LSU) || (r_cls_0 == CLS_BR));
    w_dual_ok = r_vld_0 && r_vld_1 && !w_raw && !w_waw && !w_struct &&
                !r_exc_0 && !r_exc_1 && (r_cls_0 != CLS_SYS) && (r_cls_1 != CLS_SYS);
    w_split = r_vld_0 && r_vld_1 && !w_dual_ok;
  end

  // A pair completes when EX takes its last lane: a dual/single PAIR, or SECOND.
  assign w_done = bus.ex_allin &&
                  (((r_state == ST_PAIR) && !w_split) || (r_state == ST_SECOND));
  assign bus.is_allin = !flush && ((r_state == ST_EMPTY) || w_done);
  assign w_capture = bus.is_allin && bus.id_valid_ns;

  always_comb begin
    bus.iss_valid_0 = 1'b0;
    bus.iss_pc_0    = '0;
    bus.iss_info_0  = '0;
    bus.iss_delot_0 = 1'b0;
    bus.iss_valid_1 = 1'b0;
    bus.iss_pc_1    = '0;
    bus.iss_info_1  = '0;
    bus.iss_delot_1 = 1'b0;
    case (r_state)
      ST_PAIR: begin
        if (r_vld_0) begin
          bus.iss_valid_0 = 1'b1;
          bus.iss_pc_0    = r_pc_0;
          bus.iss_info_0  = r_info_0;
          bus.iss_delot_0 = r_delot[0];
        end else if (r_vld_1) begin
          // lone slot1 is promoted to lane0
          bus.iss_valid_0 = 1'b1;
          bus.iss_pc_0    = r_pc_1;
          bus.iss_info_0  = r_info_1;
          bus.iss_delot_0 = r_delot[1];
        end
        if (w_dual_ok) begin
          bus.iss_valid_1 = 1'b1;
          bus.iss_pc_1    = r_pc_1;
          bus.iss_info_1  = r_info_1;
          bus.iss_delot_1 = r_delot[1];
        end
      end
      ST_SECOND: begin
        bus.iss_valid_0 = 1'b1;
        bus.iss_pc_0    = r_pc_1;
        bus.iss_info_0  = r_info_1;
        bus.iss_delot_0 = r_delot[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state  <= ST_EMPTY;
      r_pc_0   <= '0;
      r_pc_1   <= '0;
      r_info_0 <= '0;
      r_info_1 <= '0;
      r_vld_0  <= 1'b0;
      r_vld_1  <= 1'b0;
      r_dst_0  <= '0;
      r_dst_1  <= '0;
      r_src_0  <= '0;
      r_src_1  <= '0;
      r_cls_0  <= '0;
      r_cls_1  <= '0;
      r_exc_0  <= 1'b0;
      r_exc_1  <= 1'b0;
      r_delot  <= '0;
    end else if (w_capture) begin
      r_state  <= ST_PAIR;
      r_pc_0   <= bus.id_pc_0;
      r_pc_1   <= bus.id_pc_1;
      r_info_0 <= bus.id_info_0;
      r_info_1 <= bus.id_info_1;
      r_vld_0  <= bus.id_vld_0;
      r_vld_1  <= bus.id_vld_1;
      r_dst_0  <= bus.id_dst_0;
      r_dst_1  <= bus.id_dst_1;
      r_src_0  <= bus.id_src_0;
      r_src_1  <= bus.id_src_1;
      r_cls_0  <= bus.id_cls_0;
      r_cls_1  <= bus.id_cls_1;
      r_exc_0  <= bus.id_exc_0;
      r_exc_1  <= bus.id_exc_1;
      r_delot  <= bus.id_delot;
    end else if (w_done) begin
      r_state <= ST_EMPTY;
    end else if ((r_state == ST_PAIR) && bus.ex_allin && w_split) begin
      r_state <= ST_SECOND;
    end
  end

`ifdef IS_PERF_CNT_EN
  // Counts only lanes EX actually takes; flush does not clear the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dual_cnt   <= '0;
      perf_single_cnt <= '0;
    end else if (!flush && bus.ex_allin && bus.iss_valid_0) begin
      if (bus.iss_valid_1) perf_dual_cnt   <= perf_dual_cnt + 32'd1;
      else                 perf_single_cnt <= perf_single_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_is_dual_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_is_dual_issue_scheduler
//   Table of decoded pairs with hand-derived issue kind; expected lane
//   contents are queued when a pair is driven and popped when EX takes it.
// ---------------------------------------------------------------------------
module tb_is_dual_issue_scheduler;
  localparam int INFO_W = 55;
  localparam int CLS_W  = 3;
  localparam int K_DUAL = 0, K_SPLIT = 1, K_S0 = 2, K_S1 = 3;
  localparam logic [2:0] ALU = 3'd0, MUL = 3'd1, LSU = 3'd2, BR = 3'd3, SYS = 3'd4;
  localparam int NV = 19;

  typedef struct {
    logic [31:0] pc0, pc1;
    logic        v0, v1;
    logic [5:0]  dst0, dst1;
    logic [11:0] src1;
    logic [2:0]  cls0, cls1;
    logic        exc0, exc1;
    logic [1:0]  delot;
    int          kind;
  } vec_t;

  typedef struct {
    logic              v1;
    logic [31:0]       pc0, pc1;
    logic [INFO_W-1:0] info0, info1;
    logic              d0, d1;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush;
  logic rand_mode;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t tbl[NV];

  is_dual_issue_scheduler_if #(.INFO_W(INFO_W), .CLS_W(CLS_W)) sif();
`ifdef IS_PERF_CNT_EN
  logic [31:0] perf_dual_cnt, perf_single_cnt;
`endif

  is_dual_issue_scheduler #(.INFO_W(INFO_W), .CLS_W(CLS_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (sif.slave)
`ifdef IS_PERF_CNT_EN
    ,
    .perf_dual_cnt   (perf_dual_cnt),
    .perf_single_cnt (perf_single_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [INFO_W-1:0] info_of(input logic [31:0] pc);
    return {pc ^ 32'hDEAD_BEEF, 23'h12345};
  endfunction

  function automatic logic [5:0] mk_dst(input logic we, input logic [4:0] idx);
    return {we, idx};
  endfunction

  function automatic logic [11:0] mk_src(input logic e1, input logic [4:0] s1,
                                         input logic e0, input logic [4:0] s0);
    return {e1, s1, e0, s0};
  endfunction

  function automatic vec_t mkv(input logic v0, input logic v1,
                               input logic [5:0] d0, input logic [5:0] d1,
                               input logic [11:0] s1, input logic [2:0] c0,
                               input logic [2:0] c1, input logic e0, input logic e1,
                               input logic [1:0] dl, input int kind);
    vec_t v;
    v.pc0 = '0; v.pc1 = '0;
    v.v0 = v0; v.v1 = v1; v.dst0 = d0; v.dst1 = d1; v.src1 = s1;
    v.cls0 = c0; v.cls1 = c1; v.exc0 = e0; v.exc1 = e1; v.delot = dl; v.kind = kind;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic set_idle();
    sif.id_valid_ns = 1'b0;
    sif.id_pc_0 = '0;   sif.id_pc_1 = '0;
    sif.id_info_0 = '0; sif.id_info_1 = '0;
    sif.id_vld_0 = 1'b0; sif.id_vld_1 = 1'b0;
    sif.id_dst_0 = '0;  sif.id_dst_1 = '0;
    sif.id_src_0 = '0;  sif.id_src_1 = '0;
    sif.id_cls_0 = '0;  sif.id_cls_1 = '0;
    sif.id_exc_0 = 1'b0; sif.id_exc_1 = 1'b0;
    sif.id_delot = '0;
  endtask

  task automatic drive(input vec_t v);
    sif.id_pc_0   = v.pc0;          sif.id_pc_1   = v.pc1;
    sif.id_info_0 = info_of(v.pc0); sif.id_info_1 = info_of(v.pc1);
    sif.id_vld_0  = v.v0;           sif.id_vld_1  = v.v1;
    sif.id_dst_0  = v.dst0;         sif.id_dst_1  = v.dst1;
    sif.id_src_0  = mk_src(1'b1, 5'd2, 1'b1, 5'd1);
    sif.id_src_1  = v.src1;
    sif.id_cls_0  = v.cls0;         sif.id_cls_1  = v.cls1;
    sif.id_exc_0  = v.exc0;         sif.id_exc_1  = v.exc1;
    sif.id_delot  = v.delot;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.v1 = 1'b0; e.pc1 = '0; e.info1 = '0; e.d1 = 1'b0;
    case (v.kind)
      K_DUAL: begin
        e.v1 = 1'b1;
        e.pc0 = v.pc0; e.info0 = info_of(v.pc0); e.d0 = v.delot[0];
        e.pc1 = v.pc1; e.info1 = info_of(v.pc1); e.d1 = v.delot[1];
        sb.push_back(e);
      end
      K_SPLIT: begin
        e.pc0 = v.pc0; e.info0 = info_of(v.pc0); e.d0 = v.delot[0];
        sb.push_back(e);
        e.pc0 = v.pc1; e.info0 = info_of(v.pc1); e.d0 = v.delot[1];
        sb.push_back(e);
      end
      K_S0: begin
        e.pc0 = v.pc0; e.info0 = info_of(v.pc0); e.d0 = v.delot[0];
        sb.push_back(e);
      end
      default: begin
        e.pc0 = v.pc1; e.info0 = info_of(v.pc1); e.d0 = v.delot[1];
        sb.push_back(e);
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) sif.ex_allin = ($urandom_range(0, 3) != 0);
    #1;
  endtask

  task automatic send_pair(input vec_t v);
    int guard = 0;
    while (!sif.is_allin && guard < 100) begin
      tick();
      guard++;
    end
    if (!sif.is_allin) begin
      total++; bad++;
      $display("FAIL allin_timeout actual=0 required=1");
    end else begin
      drive(v);
      sif.id_valid_ns = 1'b1;
      push_exp(v);
      tick();
      sif.id_valid_ns = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      tick();
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec_t vf;
    exp_t e;
    rst = 1'b1; flush = 1'b0; rand_mode = 1'b0;
    set_idle();
    sif.ex_allin = 1'b1;

    tbl[0]  = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,ALU, 0,0, 2'b00, K_DUAL);
    tbl[1]  = mkv(1,1, mk_dst(1,5), mk_dst(1,6), mk_src(0,0,1,5), ALU,ALU, 0,0, 2'b01, K_SPLIT);
    tbl[2]  = mkv(1,1, mk_dst(1,7), mk_dst(1,8), mk_src(0,0,0,0), LSU,LSU, 0,0, 2'b00, K_SPLIT);
    tbl[3]  = mkv(1,1, mk_dst(0,0), mk_dst(1,9), mk_src(1,2,1,1), BR, ALU, 0,0, 2'b10, K_DUAL);
    tbl[4]  = mkv(1,1, mk_dst(1,0), mk_dst(1,0), mk_src(1,2,1,1), ALU,ALU, 0,0, 2'b00, K_DUAL);
    tbl[5]  = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,ALU, 0,1, 2'b00, K_SPLIT);
    tbl[6]  = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), MUL,MUL, 0,0, 2'b00, K_SPLIT);
    tbl[7]  = mkv(1,1, mk_dst(0,0), mk_dst(0,0), mk_src(0,0,0,0), BR, BR,  0,0, 2'b00, K_SPLIT);
    tbl[8]  = mkv(1,1, mk_dst(1,7), mk_dst(1,7), mk_src(1,2,1,1), ALU,ALU, 0,0, 2'b00, K_SPLIT);
    tbl[9]  = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), SYS,ALU, 0,0, 2'b00, K_SPLIT);
    tbl[10] = mkv(1,1, mk_dst(1,9), mk_dst(1,4), mk_src(1,9,0,0), ALU,ALU, 0,0, 2'b10, K_SPLIT);
    tbl[11] = mkv(1,1, mk_dst(1,5), mk_dst(1,6), mk_src(0,0,0,5), ALU,ALU, 0,0, 2'b00, K_DUAL);
    tbl[12] = mkv(1,1, mk_dst(0,5), mk_dst(1,6), mk_src(0,0,1,5), ALU,ALU, 0,0, 2'b00, K_DUAL);
    tbl[13] = mkv(1,0, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,ALU, 0,0, 2'b01, K_S0);
    tbl[14] = mkv(0,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,ALU, 0,0, 2'b10, K_S1);
    tbl[15] = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,MUL, 0,0, 2'b00, K_DUAL);
    tbl[16] = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), ALU,ALU, 1,0, 2'b00, K_SPLIT);
    tbl[17] = mkv(1,1, mk_dst(1,3), mk_dst(1,4), mk_src(1,2,1,1), MUL,LSU, 0,0, 2'b00, K_DUAL);
    tbl[18] = mkv(1,1, mk_dst(1,0), mk_dst(1,4), mk_src(0,0,1,0), ALU,ALU, 0,0, 2'b00, K_DUAL);
    for (int i = 0; i < NV; i++) begin
      tbl[i].pc0 = 32'h1000 + 32'(i * 16);
      tbl[i].pc1 = tbl[i].pc0 + 32'd4;
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_is_allin", 64'(sif.is_allin), 64'd1);
    chk("rst_valid_0", 64'(sif.iss_valid_0), 64'd0);
    chk("rst_valid_1", 64'(sif.iss_valid_1), 64'd0);
    chk("rst_pc_0", 64'(sif.iss_pc_0), 64'd0);
    chk("rst_delot_0", 64'(sif.iss_delot_0), 64'd0);

    fork
      forever begin
        @(negedge clk);
        if (!rst && !flush && sif.ex_allin && sif.iss_valid_0) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_issue actual_pc=%0h required=none", sif.iss_pc_0);
          end else begin
            e = sb.pop_front();
            chk("lane1_valid", 64'(sif.iss_valid_1), 64'(e.v1));
            chk("lane0_pc", 64'(sif.iss_pc_0), 64'(e.pc0));
            chk("lane0_info", 64'(sif.iss_info_0), 64'(e.info0));
            chk("lane0_delot", 64'(sif.iss_delot_0), 64'(e.d0));
            if (e.v1) begin
              chk("lane1_pc", 64'(sif.iss_pc_1), 64'(e.pc1));
              chk("lane1_info", 64'(sif.iss_info_1), 64'(e.info1));
              chk("lane1_delot", 64'(sif.iss_delot_1), 64'(e.d1));
            end
          end
        end
      end
    join_none

    // table pass, EX always ready (back-to-back captures)
    for (int i = 0; i < NV; i++) send_pair(tbl[i]);
    drain();

    // table pass with random EX back-pressure
    rand_mode = 1'b1;
    for (int i = 0; i < NV; i++) send_pair(tbl[i]);
    rand_mode = 1'b0;
    sif.ex_allin = 1'b1;
    drain();

    // split timing: lane0 only at N, slot1 on lane0 and is_allin at N+1
    drive(tbl[1]);
    sif.id_valid_ns = 1'b1;
    push_exp(tbl[1]);
    @(posedge clk); #1 sif.id_valid_ns = 1'b0;
    @(negedge clk);
    chk("split_n_allin", 64'(sif.is_allin), 64'd0);
    chk("split_n_pc0", 64'(sif.iss_pc_0), 64'(tbl[1].pc0));
    @(negedge clk);
    chk("split_n1_allin", 64'(sif.is_allin), 64'd1);
    chk("split_n1_pc0", 64'(sif.iss_pc_0), 64'(tbl[1].pc1));
    drain();

    // EX stall on a split LSU pair: lanes frozen, no ID acceptance
    @(posedge clk); #1 sif.ex_allin = 1'b0;
    drive(tbl[2]);
    sif.id_valid_ns = 1'b1;
    push_exp(tbl[2]);
    @(posedge clk); #1 sif.id_valid_ns = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid_0", 64'(sif.iss_valid_0), 64'd1);
      chk("stall_pc_0", 64'(sif.iss_pc_0), 64'(tbl[2].pc0));
      chk("stall_valid_1", 64'(sif.iss_valid_1), 64'd0);
      chk("stall_allin", 64'(sif.is_allin), 64'd0);
    end
    @(posedge clk); #1 sif.ex_allin = 1'b1;
    drain();

    // branch + delay slot split, flush while delay slot pending
    vf = mkv(1,1, mk_dst(1,31), mk_dst(1,4), mk_src(0,0,1,31), BR,ALU, 0,0, 2'b10, K_S0);
    vf.pc0 = 32'h2000; vf.pc1 = 32'h2004;
    @(posedge clk); #1;
    drive(vf);
    sif.id_valid_ns = 1'b1;
    push_exp(vf);
    @(posedge clk); #1 sif.id_valid_ns = 1'b0;
    @(posedge clk); #1 sif.ex_allin = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("second_valid_0", 64'(sif.iss_valid_0), 64'd1);
    chk("second_pc_0", 64'(sif.iss_pc_0), 64'(vf.pc1));
    chk("second_delot_0", 64'(sif.iss_delot_0), 64'd1);
    @(posedge clk); #1 flush = 1'b0; sif.ex_allin = 1'b1;
    @(negedge clk);
    chk("flush_valid_0", 64'(sif.iss_valid_0), 64'd0);
    chk("flush_valid_1", 64'(sif.iss_valid_1), 64'd0);
    chk("flush_pc_0", 64'(sif.iss_pc_0), 64'd0);
    chk("flush_delot_0", 64'(sif.iss_delot_0), 64'd0);
    chk("flush_allin", 64'(sif.is_allin), 64'd1);
    drain();

    // flush and id_valid_ns together: nothing captured
    @(posedge clk); #1;
    drive(tbl[0]);
    sif.id_valid_ns = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; sif.id_valid_ns = 1'b0;
    @(negedge clk);
    chk("flushcap_valid_0", 64'(sif.iss_valid_0), 64'd0);
    chk("flushcap_allin", 64'(sif.is_allin), 64'd1);
    repeat (3) tick();
    drain();

`ifdef IS_PERF_CNT_EN
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    send_pair(tbl[0]);
    send_pair(tbl[1]);
    send_pair(tbl[3]);
    send_pair(tbl[2]);
    send_pair(tbl[4]);
    drain();
    @(negedge clk);
    chk("perf_dual", 64'(perf_dual_cnt), 64'd3);
    chk("perf_single", 64'(perf_single_cnt), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
